// File: rtl/ltssm_pkg.sv
// Shared LTSSM constants: ordered-set symbols, substate encodings, OS byte offsets.
// Latency: n/a (declarations and one pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   PAD / TS1 / TS2         symbol values used in ordered sets
//   DETECT_QUIET..CFG_IDLE  4-bit LTSSM substate encoding
//   OS_*_BYTE               byte offsets inside a 16-byte training set
//   os_expect_t             what the current substate expects to see
//   expect_for()            substate -> expectation decode
package ltssm_pkg;

  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] TS1 = 8'h2A;
  localparam logic [7:0] TS2 = 8'h25;

  localparam logic [3:0] DETECT_QUIET        = 4'd0;
  localparam logic [3:0] DETECT_ACTIVE       = 4'd1;
  localparam logic [3:0] POLLING_ACTIVE      = 4'd2;
  localparam logic [3:0] POLLING_CONFIG      = 4'd3;
  localparam logic [3:0] CFG_LINKWIDTH_START = 4'd4;
  localparam logic [3:0] CFG_LINKWIDTH_ACCEPT= 4'd5;
  localparam logic [3:0] CFG_LANENUM_WAIT    = 4'd6;
  localparam logic [3:0] CFG_LANENUM_ACCEPT  = 4'd7;
  localparam logic [3:0] CFG_COMPLETE        = 4'd8;
  localparam logic [3:0] CFG_IDLE            = 4'd9;

  localparam int OS_LINK_BYTE = 1;
  localparam int OS_LANE_BYTE = 2;
  localparam int OS_NFTS_BYTE = 3;
  localparam int OS_RATE_BYTE = 4;
  localparam int OS_TCTL_BYTE = 5;
  localparam int OS_ID_FIRST  = 9;
  localparam int OS_ID_LAST   = 15;
  localparam int UPCFG_BIT    = 6;  // bit within the training-control byte

  typedef struct packed {
    logic enabled;   // substate checks ordered sets at all
    logic ts1_ok;    // TS1 identifier accepted
    logic ts2_ok;    // TS2 identifier accepted
    logic link_pad;  // link field must be PAD (else link_number)
    logic lane_pad;  // lane field must be PAD (else the lane index)
  } os_expect_t;

  function automatic os_expect_t expect_for(input logic [3:0] st);
    os_expect_t e;
    e = '0;
    case (st)
      POLLING_ACTIVE:      e = '{enabled: 1'b1, ts1_ok: 1'b1, ts2_ok: 1'b1, link_pad: 1'b1, lane_pad: 1'b1};
      POLLING_CONFIG:      e = '{enabled: 1'b1, ts1_ok: 1'b0, ts2_ok: 1'b1, link_pad: 1'b1, lane_pad: 1'b1};
      CFG_LINKWIDTH_START: e = '{enabled: 1'b1, ts1_ok: 1'b1, ts2_ok: 1'b0, link_pad: 1'b0, lane_pad: 1'b1};
      CFG_LINKWIDTH_ACCEPT,
      CFG_LANENUM_WAIT,
      CFG_LANENUM_ACCEPT:  e = '{enabled: 1'b1, ts1_ok: 1'b1, ts2_ok: 1'b0, link_pad: 1'b0, lane_pad: 1'b0};
      CFG_COMPLETE:        e = '{enabled: 1'b1, ts1_ok: 1'b0, ts2_ok: 1'b1, link_pad: 1'b0, lane_pad: 1'b0};
      default:             e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/os_lane_checker.sv
// One lane: compares an ordered set against the substate expectation and counts consecutive matches.
// Latency: count/done/mismatch registered, 1 cycle after os_valid; hit is combinational.
// Backpressure: none, one set per os_valid strobe is always consumed.
//
// Ports: clk, reset (sync, active-high); clear forces count to 0 and suppresses checking;
//   ts1_ok/ts2_ok/link_pad/lane_pad select the expectation; link_number expected link;
//   os_valid/os_data one set; count/done/mismatch lane status; hit = set counted this cycle.
// Optional: OS_CHECK_RATE_CONSISTENT_EN adds a per-lane rate-id latch to the match.
module os_lane_checker
  import ltssm_pkg::*;
#(
  parameter int LANE_IDX     = 0,
  parameter int COUNT_TARGET = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             ts1_ok,
  input  logic             ts2_ok,
  input  logic             link_pad,
  input  logic             lane_pad,
  input  logic [7:0]       link_number,
  input  logic             os_valid,
  input  logic [127:0]     os_data,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             mismatch,
  output logic             hit
);

  localparam logic [CNT_W-1:0] TGT = CNT_W'(COUNT_TARGET);

  logic             id_ts1;
  logic             id_ts2;
  logic             link_ok;
  logic             lane_ok;
  logic             rate_ok;
  logic             set_ok;
  logic             miss;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       rate_byte;

  // Bytes 0, 3 and 6-8 carry nothing this checker cares about.
  logic unused_bytes;
  assign unused_bytes = ^{os_data[71:24], os_data[7:0]};

  assign rate_byte = os_data[8*OS_RATE_BYTE +: 8];

  // All seven identifier symbols must agree on one kind.
  always_comb begin
    id_ts1 = 1'b1;
    id_ts2 = 1'b1;
    for (int b = OS_ID_FIRST; b <= OS_ID_LAST; b++) begin
      id_ts1 = id_ts1 & (os_data[8*b +: 8] == TS1);
      id_ts2 = id_ts2 & (os_data[8*b +: 8] == TS2);
    end
  end

  assign link_ok = os_data[8*OS_LINK_BYTE +: 8] == (link_pad ? PAD : link_number);
  assign lane_ok = os_data[8*OS_LANE_BYTE +: 8] == (lane_pad ? PAD : 8'(LANE_IDX));

`ifdef OS_CHECK_RATE_CONSISTENT_EN
  logic       rate_vld_q;
  logic [7:0] rate_q;

  // Until the first match after a clear there is nothing to compare against.
  assign rate_ok = !rate_vld_q || (rate_byte == rate_q);

  always_ff @(posedge clk) begin
    if (reset || clear || miss) begin
      rate_vld_q <= 1'b0;
      rate_q     <= '0;
    end else if (hit && !rate_vld_q) begin
      rate_vld_q <= 1'b1;
      rate_q     <= rate_byte;
    end
  end
`else
  assign rate_ok = 1'b1;
`endif

  assign set_ok = ((ts1_ok & id_ts1) | (ts2_ok & id_ts2)) & link_ok & lane_ok & rate_ok;
  assign hit    = os_valid & ~clear & set_ok;
  assign miss   = os_valid & ~clear & ~set_ok;

  always_comb begin
    cnt_next = count;
    if (clear || miss) begin
      cnt_next = '0;
    end else if (hit) begin
      cnt_next = (count >= TGT) ? TGT : count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      count    <= cnt_next;
      done     <= (cnt_next == TGT);
      mismatch <= miss;
    end
  end

endmodule

// File: rtl/os_checker_multilane.sv
// Multi-lane TS1/TS2 checker: per-lane consecutive-match counts and an all-lanes-done flag.
// Latency: lane_count/lane_done/mismatch/rate_id 1 cycle after os_valid; all_done comb from lane_done.
// Backpressure: none, every strobed set is checked in the cycle it arrives.
//
// Ports: clk, reset (sync, active-high); substate LTSSM substate; link_number expected link;
//   lane_mask active lanes; os_valid/os_data per-lane sets (lane i at [128*i +: 128]);
//   lane_count/lane_done/mismatch per lane; all_done; rate_id/upconfigure_capability from
//   the last match on the lowest active lane.
// Optional: OS_CHECK_RATE_CONSISTENT_EN (see os_lane_checker).
module os_checker_multilane
  import ltssm_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int COUNT_TARGET = 8,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             substate,
  input  logic [7:0]             link_number,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [LANES-1:0]       os_valid,
  input  logic [LANES*128-1:0]   os_data,
  output logic [LANES*CNT_W-1:0] lane_count,
  output logic [LANES-1:0]       lane_done,
  output logic                   all_done,
  output logic [LANES-1:0]       mismatch,
  output logic [7:0]             rate_id,
  output logic                   upconfigure_capability
);

  logic [3:0]       substate_q;
  logic             sub_changed;
  os_expect_t       exp_c;
  logic [LANES-1:0] hit;
  logic             cap_hit;
  logic [7:0]       cap_rate;
  logic             cap_upc;

  // While substate differs from its registered copy, the cycle is a transition:
  // counts clear and the incoming set is dropped.
  assign sub_changed = (substate != substate_q);
  assign exp_c       = expect_for(substate_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      substate_q <= DETECT_QUIET;
    end else begin
      substate_q <= substate;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    os_lane_checker #(
      .LANE_IDX    (i),
      .COUNT_TARGET(COUNT_TARGET),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clear      (sub_changed | ~exp_c.enabled | ~lane_mask[i]),
      .ts1_ok     (exp_c.ts1_ok),
      .ts2_ok     (exp_c.ts2_ok),
      .link_pad   (exp_c.link_pad),
      .lane_pad   (exp_c.lane_pad),
      .link_number(link_number),
      .os_valid   (os_valid[i]),
      .os_data    (os_data[128*i +: 128]),
      .count      (lane_count[CNT_W*i +: CNT_W]),
      .done       (lane_done[i]),
      .mismatch   (mismatch[i]),
      .hit        (hit[i])
    );
  end

  // Walk high to low so the lowest active lane is the last (winning) assignment.
  always_comb begin
    cap_hit  = 1'b0;
    cap_rate = '0;
    cap_upc  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_mask[i]) begin
        cap_hit  = hit[i];
        cap_rate = os_data[128*i + 8*OS_RATE_BYTE +: 8];
        cap_upc  = os_data[128*i + 8*OS_TCTL_BYTE + UPCFG_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_id                <= '0;
      upconfigure_capability <= 1'b0;
    end else if (cap_hit) begin
      rate_id                <= cap_rate;
      upconfigure_capability <= cap_upc;
    end
  end

  // Uses the live mask so a lane dropped this cycle stops holding all_done back at once.
  assign all_done = (|lane_mask) && (&(lane_done | ~lane_mask));

endmodule

// File: tb/tb_os_checker_multilane.sv
module tb_os_checker_multilane;
  import ltssm_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   substate;
  logic [7:0]   link_number;
  logic [3:0]   lane_mask;
  logic [3:0]   os_valid;
  logic [511:0] os_data;
  logic [31:0]  lane_count;
  logic [3:0]   lane_done;
  logic         all_done;
  logic [3:0]   mismatch;
  logic [7:0]   rate_id;
  logic         upconfigure_capability;

  os_checker_multilane #(.LANES(4), .COUNT_TARGET(8), .CNT_W(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .substate              (substate),
    .link_number           (link_number),
    .lane_mask             (lane_mask),
    .os_valid              (os_valid),
    .os_data               (os_data),
    .lane_count            (lane_count),
    .lane_done             (lane_done),
    .all_done              (all_done),
    .mismatch              (mismatch),
    .rate_id               (rate_id),
    .upconfigure_capability(upconfigure_capability)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cnt;
    logic [3:0]  done;
    logic        all_d;
    logic [3:0]  mm;
    logic [7:0]  rate;
    logic        upc;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  obs_t  got_q[$];
  obs_t  e, g;
  string nm;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [127:0] mk_os(input logic [7:0] id, input logic [7:0] link,
                                         input logic [7:0] lane, input logic [7:0] rate,
                                         input logic [7:0] tctl);
    logic [127:0] s;
    s = '0;
    s[7:0]   = 8'hBC;
    s[15:8]  = link;
    s[23:16] = lane;
    s[31:24] = 8'h10;
    s[39:32] = rate;
    s[47:40] = tctl;
    for (int b = 9; b < 16; b++) s[8*b +: 8] = id;
    return s;
  endfunction

  function automatic logic [511:0] rep(input logic [127:0] s);
    return {4{s}};
  endfunction

  function automatic obs_t mk_exp(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                                  input logic [7:0] c3, input logic [3:0] dn, input logic ad,
                                  input logic [3:0] mm, input logic [7:0] rate, input logic upc);
    obs_t o;
    o.cnt = {c3, c2, c1, c0};
    o.done = dn;
    o.all_d = ad;
    o.mm = mm;
    o.rate = rate;
    o.upc = upc;
    return o;
  endfunction

  task automatic push(input string n, input obs_t x);
    nm_q.push_back(n);
    exp_q.push_back(x);
  endtask

  // Drive one cycle of stimulus and record what the DUT shows just after the edge.
  task automatic cyc(input logic [3:0] vld, input logic [511:0] dat);
    obs_t o;
    os_valid = vld;
    os_data  = dat;
    @(posedge clk);
    #1;
    o.cnt = lane_count; o.done = lane_done; o.all_d = all_done;
    o.mm = mismatch; o.rate = rate_id; o.upc = upconfigure_capability;
    got_q.push_back(o);
    os_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; substate = DETECT_QUIET;
    push("reset", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h00, 0));
    cyc(4'hF, rep(mk_os(TS1, PAD, PAD, 8'h02, 8'h40)));
    reset = 1'b0;
    push("dq_disabled", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h00, 0));
    cyc(4'hF, rep(mk_os(TS1, PAD, PAD, 8'h02, 8'h40)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_polling_active();
    logic [511:0] d;
    d = rep(mk_os(TS2, PAD, PAD, 8'h02, 8'h40));
    substate = POLLING_ACTIVE;
    push("pa_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h00, 0));
    cyc(4'hF, d);
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("pa_count%0d", k),
           mk_exp(8'(k),8'(k),8'(k),8'(k), (k == 8) ? 4'hF : 4'h0, k == 8, 4'h0, 8'h02, 1));
      cyc(4'hF, d);
    end
    push("pa_saturate", mk_exp(8,8,8,8, 4'hF, 1, 4'h0, 8'h02, 1));
    cyc(4'hF, d);
    push("pa_hold", mk_exp(8,8,8,8, 4'hF, 1, 4'h0, 8'h02, 1));
    cyc(4'h0, d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_polling_config();
    logic [511:0] d, bad;
    d   = rep(mk_os(TS2, PAD, PAD, 8'h05, 8'h00));
    bad = rep(mk_os(8'hAA, PAD, PAD, 8'h05, 8'h00));
    substate = POLLING_CONFIG;
    push("pc_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h02, 1));
    cyc(4'h0, d);
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("pc_lane2_%0d", k), mk_exp(0,0,8'(k),0, 4'h0, 0, 4'h0, 8'h02, 1));
      cyc(4'b0100, d);
    end
    push("pc_bad_ident", mk_exp(0,0,0,0, 4'h0, 0, 4'b0100, 8'h02, 1));
    cyc(4'b0100, bad);
    for (int k = 1; k <= 2; k++) begin
      push($sformatf("pc_recover%0d", k), mk_exp(0,0,8'(k),0, 4'h0, 0, 4'h0, 8'h02, 1));
      cyc(4'b0100, d);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_disabled();
    logic [511:0] bad;
    bad = rep(mk_os(8'hAA, 8'h33, 8'h44, 8'h05, 8'h00));
    substate = DETECT_ACTIVE;
    push("dis_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h02, 1));
    cyc(4'hF, bad);
    push("dis_no_mismatch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h02, 1));
    cyc(4'hF, bad);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_link_width_start();
    logic [511:0] d, bad;
    d   = rep(mk_os(TS1, 8'h01, PAD, 8'h03, 8'h00));
    bad = rep(mk_os(TS1, 8'h02, PAD, 8'h03, 8'h00));
    substate = CFG_LINKWIDTH_START;
    link_number = 8'h01;
    push("lws_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h02, 1));
    cyc(4'h0, d);
    for (int k = 1; k <= 2; k++) begin
      push($sformatf("lws_count%0d", k), mk_exp(8'(k),8'(k),8'(k),8'(k), 4'h0, 0, 4'h0, 8'h03, 0));
      cyc(4'hF, d);
    end
    push("lws_bad_link", mk_exp(0,0,0,0, 4'h0, 0, 4'hF, 8'h03, 0));
    cyc(4'hF, bad);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_config_complete();
    logic [511:0] good, bad1;
    for (int i = 0; i < 4; i++) good[128*i +: 128] = mk_os(TS2, 8'h01, 8'(i), 8'h07, 8'h40);
    bad1 = good;
    bad1[128 +: 128] = mk_os(TS2, 8'h01, 8'h00, 8'h07, 8'h40);
    substate = CFG_COMPLETE;
    link_number = 8'h01;
    push("cc_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h03, 0));
    cyc(4'h0, good);
    push("cc_lane1_bad", mk_exp(1,0,1,1, 4'h0, 0, 4'b0010, 8'h07, 1));
    cyc(4'hF, bad1);
    push("cc_lane1_good", mk_exp(2,1,2,2, 4'h0, 0, 4'h0, 8'h07, 1));
    cyc(4'hF, good);
    lane_mask = 4'b1101;
    for (int k = 3; k <= 8; k++) begin
      push($sformatf("cc_masked%0d", k),
           mk_exp(8'(k),0,8'(k),8'(k), (k == 8) ? 4'b1101 : 4'h0, k == 8, 4'h0, 8'h07, 1));
      cyc(4'hF, good);
    end
    lane_mask = 4'hF;
    push("cc_unmask_alldone", mk_exp(8,0,8,8, 4'b1101, 0, 4'h0, 8'h07, 1));
    cyc(4'h0, good);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_substate_switch();
    logic [511:0] d;
    d = rep(mk_os(TS2, PAD, PAD, 8'h02, 8'h40));
    substate = POLLING_ACTIVE;
    push("sw_enter_pa", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h07, 1));
    cyc(4'hF, d);
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("sw_pa%0d", k), mk_exp(8'(k),8'(k),8'(k),8'(k), 4'h0, 0, 4'h0, 8'h02, 1));
      cyc(4'hF, d);
    end
    substate = POLLING_CONFIG;
    push("sw_switch_drop", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h02, 1));
    cyc(4'hF, d);
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("sw_pc%0d", k), mk_exp(8'(k),8'(k),8'(k),8'(k), 4'h0, 0, 4'h0, 8'h02, 1));
      cyc(4'hF, d);
    end
    reset = 1'b1;
    push("sw_mid_reset", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h00, 0));
    cyc(4'hF, d);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  task automatic test_rate_consistency();
    logic [511:0] r4, r2;
    r4 = rep(mk_os(TS1, PAD, PAD, 8'h04, 8'h00));
    r2 = rep(mk_os(TS1, PAD, PAD, 8'h02, 8'h00));
    substate = POLLING_ACTIVE;
    push("rc_switch", mk_exp(0,0,0,0, 4'h0, 0, 4'h0, 8'h00, 0));
    cyc(4'h0, r4);
    push("rc_first", mk_exp(1,1,1,1, 4'h0, 0, 4'h0, 8'h04, 0));
    cyc(4'hF, r4);
    push("rc_second", mk_exp(2,2,2,2, 4'h0, 0, 4'h0, 8'h04, 0));
    cyc(4'hF, r4);
`ifdef OS_CHECK_RATE_CONSISTENT_EN
    push("rc_rate_change", mk_exp(0,0,0,0, 4'h0, 0, 4'hF, 8'h04, 0));
    cyc(4'hF, r2);
    push("rc_relatch", mk_exp(1,1,1,1, 4'h0, 0, 4'h0, 8'h02, 0));
    cyc(4'hF, r2);
`else
    push("rc_rate_change", mk_exp(3,3,3,3, 4'h0, 0, 4'h0, 8'h02, 0));
    cyc(4'hF, r2);
    push("rc_continue", mk_exp(4,4,4,4, 4'h0, 0, 4'h0, 8'h02, 0));
    cyc(4'hF, r2);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no sample, want %h", nm, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s: got cnt=%h done=%b all=%b mm=%b rate=%h upc=%b want cnt=%h done=%b all=%b mm=%b rate=%h upc=%b", nm, g.cnt, g.done, g.all_d, g.mm, g.rate, g.upc, e.cnt, e.done, e.all_d, e.mm, e.rate, e.upc); end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    substate    = DETECT_QUIET;
    link_number = 8'h00;
    lane_mask   = 4'hF;
    os_valid    = 4'h0;
    os_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_polling_active();
    test_polling_config();
    test_disabled();
    test_link_width_start();
    test_config_complete();
    test_substate_switch();
    test_rate_consistency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/os_checker_multilane.md
Name: os_checker_multilane

Overview:
- Parametrised successor to the single-lane ordered-set checker.
- Checks TS1/TS2 ordered sets on LANES lanes in parallel against the expectation set by the current LTSSM substate.
- Keeps a saturating count of consecutive matching sets per lane and flags when every active lane has reached COUNT_TARGET.
- Sits between the per-lane OS decoders and the LTSSM controller, replacing the external counter.

Parameters:
- LANES, 4, number of lanes checked in parallel (1..16).
- COUNT_TARGET, 8, consecutive matches needed for lane_done (1..255).
- CNT_W, 8, per-lane counter width; must hold COUNT_TARGET.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- substate  in  4  current LTSSM substate (package encoding).
- link_number  in  8  expected link number.
- lane_mask  in  LANES  1 = lane active; inactive lanes are ignored for all_done.
- os_valid  in  LANES  per-lane ordered-set strobe, one cycle per set.
- os_data  in  LANES*128  per-lane ordered set; lane i occupies bits [128*i+127:128*i].
- lane_count  out  LANES*CNT_W  per-lane consecutive-match count.
- lane_done  out  LANES  lane count == COUNT_TARGET.
- all_done  out  1  every active lane done and lane_mask != 0.
- mismatch  out  LANES  one-cycle pulse: valid set failed the check.
- rate_id  out  8  byte 4 of the last matching set on the lowest active lane.
- upconfigure_capability  out  1  bit 6 of byte 5 from the same set.

Behaviour:
- Set layout (byte n = bits [8n+7:8n]):
  - byte0 ignored
  - byte1 link number
  - byte2 lane number
  - byte3 N_FTS
  - byte4 rate id
  - byte5 training control
  - bytes 6-8 ignored
  - bytes 9-15 identifier; all seven must equal TS1 (2A) or all equal TS2 (25)
- Expectation by substate (lane i's expected lane number = i):
  - pollingActive: TS1 or TS2; link = PAD; lane = PAD.
  - pollingConfiguration: TS2; link = PAD; lane = PAD.
  - configurationLinkWidthStart: TS1; link = link_number; lane = PAD.
  - configurationLinkWidthAccept, configurationLanenumWait, configurationLanenumAccept: TS1; link = link_number; lane = i.
  - configurationComplete: TS2; link = link_number; lane = i.
  - Any other substate: checking disabled; counts forced to 0; no mismatch pulses.
- Per-lane counter, evaluated at each clk edge:
  - os_valid=1 and match: count+1, saturating at COUNT_TARGET.
  - os_valid=1 and no match: count=0; mismatch pulses next cycle.
  - os_valid=0: count holds.
  - Lane with lane_mask=0: count=0, no mismatch.
- Substate change: substate is registered internally. When it differs from the registered value, all counts clear that cycle and the incoming set is not counted. The first countable set arrives the cycle after the change.
- Latency: all outputs registered. lane_count/lane_done reflect a set one cycle after its os_valid edge. all_done follows lane_done in the same cycle.
- rate_id/upconfigure_capability: update on a match on the lowest-index active lane; hold otherwise.
- Reset: all counts 0, lane_done 0, all_done 0, mismatch 0, rate_id 0, upconfigure_capability 0, registered substate = detectQuiet. Reset mid-sequence discards progress.
- lane_mask change mid-operation: a newly masked lane clears its count next cycle. all_done is recomputed combinationally from the registered lane_done.

Optional Feature:
- Macro: OS_CHECK_RATE_CONSISTENT_EN.
- Defined: each lane latches the rate id of its first match after a count clear. A later set with a different rate id is treated as a mismatch (count=0, mismatch pulse), and the latch reloads on the next match.
- Undefined: rate id is not part of the match.

Decomposition:
- Shared package ltssm_pkg holds:
  - PAD=F7, TS1=2A, TS2=25.
  - 4-bit substate encodings: detectQuiet=0 .. configurationIdle=9.
  - OS byte-offset constants.
- Sub-module os_lane_checker: one lane's compare logic, counter and optional rate latch. Instantiated LANES times by generate.
- The top level holds the substate register, all_done reduction and rate capture.

Test Plan:
- LANES=4, COUNT_TARGET=8, pollingActive; 8 valid TS2 sets (link/lane = F7) on all lanes -> lane_count 1..8, lane_done=F one cycle after the 8th, all_done=1.
- pollingConfiguration; lane 2 receives 3 TS2, then a set with identifier bytes = AA, then 2 TS2 -> lane 2 count 3,0,1,2; mismatch[2] pulses once; all_done=0.
- configurationLinkWidthStart, link_number=01; TS1 with byte1=01, byte2=F7 on all lanes -> counts increment. Same set with byte1=02 -> counts 0, mismatch=F.
- configurationComplete; lane 1 sends TS2 with byte2=00 -> mismatch[1]; byte2=01 -> counts. lane_mask=4'b1101 with lanes 0,2,3 at 8 -> all_done=1.
- Substate switch after 5 matches, with os_valid high on the switch cycle -> counts 0, that set is not counted. reset asserted at count 6 -> all outputs 0 next cycle.
- With OS_CHECK_RATE_CONSISTENT_EN defined: rate byte 04,04,02 -> third set is a mismatch and the count drops to 0. Without the macro -> count 3, rate_id=02.
